// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types: machine word, register index and writeback queue entry.
package cpu_types_pkg;

    localparam int WORD_BITS = 32;
    localparam int REG_BITS  = 5;

    typedef logic [WORD_BITS-1:0] word_t;
    typedef logic [REG_BITS-1:0]  regbits_t;

    typedef struct packed {
        regbits_t sel;
        word_t    dat;
    } wbq_entry_t;

endpackage

// File: rtl/wbq_fwd_match.sv
// Forwarding lookup for one read select: scans the live queue entries from
// head to tail and reports the youngest entry whose destination matches.
module wbq_fwd_match
    import cpu_types_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  wbq_entry_t [DEPTH-1:0]           entries_i,
    input  logic [$clog2(DEPTH)-1:0]         head_i,
    input  logic [$clog2(DEPTH+1)-1:0]       count_i,
    input  regbits_t                         rsel_i,
    output logic                             hit_o,
    output word_t                            dat_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [PTR_W-1:0] idx;

    // Later (younger) matches overwrite earlier ones, so the last hit wins.
    always_comb begin
        hit_o = 1'b0;
        dat_o = '0;
        idx   = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            idx = head_i + PTR_W'(i);
            if ((CNT_W'(i) < count_i) && (rsel_i != '0) &&
                (entries_i[idx].sel == rsel_i)) begin
                hit_o = 1'b1;
                dat_o = entries_i[idx].dat;
            end
        end
    end

endmodule

// File: rtl/writeback_queue.sv
// In-order writeback FIFO in front of the register file write port, with
// read-select forwarding of the youngest pending value.
module writeback_queue
    import cpu_types_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int WORD_W = WORD_BITS,
    parameter int REG_W  = REG_BITS
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic                         wb_valid,
    output logic                         wb_ready,
    input  logic [REG_W-1:0]             wb_sel,
    input  logic [WORD_W-1:0]            wb_dat,
    input  logic                         rf_grant,
    output logic                         rf_wen,
    output logic [REG_W-1:0]             rf_wsel,
    output logic [WORD_W-1:0]            rf_wdat,
    input  logic [REG_W-1:0]             rsel1,
    input  logic [REG_W-1:0]             rsel2,
    output logic                         fwd_hit1,
    output logic                         fwd_hit2,
    output logic [WORD_W-1:0]            fwd_dat1,
    output logic [WORD_W-1:0]            fwd_dat2,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    wbq_entry_t [DEPTH-1:0] entries_q;
    logic [PTR_W-1:0]       head_q, head_d;
    logic [PTR_W-1:0]       tail_q, tail_d;
    logic [CNT_W-1:0]       count_q, count_d;
    logic                   store;
    logic                   pop;

    // Handshake, pointer and occupancy next-state; register-0 pushes complete but store nothing.
    always_comb begin
        pop      = (count_q != '0) && rf_grant;
        wb_ready = (count_q < FULL) || rf_grant;
        store    = wb_valid && wb_ready && (wb_sel != '0);
        head_d   = pop   ? head_q + PTR_W'(1) : head_q;
        tail_d   = store ? tail_q + PTR_W'(1) : tail_q;
        count_d  = count_q;
        case ({store, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Storage and pointer state; reset discards every queued entry.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                entries_q[i] <= '0;
            end
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (store) begin
                entries_q[tail_q] <= '{sel: wb_sel, dat: wb_dat};
            end
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Register file port driven straight from the head entry, zeroed when empty.
    always_comb begin
        rf_wen  = pop;
        rf_wsel = '0;
        rf_wdat = '0;
        if (count_q != '0) begin
            rf_wsel = entries_q[head_q].sel;
            rf_wdat = entries_q[head_q].dat;
        end
        count = count_q;
    end

    wbq_fwd_match #(.DEPTH(DEPTH)) u_fwd1 (
        .entries_i (entries_q),
        .head_i    (head_q),
        .count_i   (count_q),
        .rsel_i    (rsel1),
        .hit_o     (fwd_hit1),
        .dat_o     (fwd_dat1)
    );

    wbq_fwd_match #(.DEPTH(DEPTH)) u_fwd2 (
        .entries_i (entries_q),
        .head_i    (head_q),
        .count_i   (count_q),
        .rsel_i    (rsel2),
        .hit_o     (fwd_hit2),
        .dat_o     (fwd_dat2)
    );

endmodule

// File: tb/tb_writeback_queue.sv
// Directed self-checking bench for writeback_queue.
module tb_writeback_queue;

    logic        CLK;
    logic        RST;
    logic        wb_valid;
    logic        wb_ready;
    logic [4:0]  wb_sel;
    logic [31:0] wb_dat;
    logic        rf_grant;
    logic        rf_wen;
    logic [4:0]  rf_wsel;
    logic [31:0] rf_wdat;
    logic [4:0]  rsel1, rsel2;
    logic        fwd_hit1, fwd_hit2;
    logic [31:0] fwd_dat1, fwd_dat2;
    logic [2:0]  count;

    int checks = 0;
    int errors = 0;

    logic [4:0]  exp_sel[$];
    logic [31:0] exp_dat[$];

    writeback_queue #(.DEPTH(4), .WORD_W(32), .REG_W(5)) dut (
        .CLK      (CLK),
        .RST      (RST),
        .wb_valid (wb_valid),
        .wb_ready (wb_ready),
        .wb_sel   (wb_sel),
        .wb_dat   (wb_dat),
        .rf_grant (rf_grant),
        .rf_wen   (rf_wen),
        .rf_wsel  (rf_wsel),
        .rf_wdat  (rf_wdat),
        .rsel1    (rsel1),
        .rsel2    (rsel2),
        .fwd_hit1 (fwd_hit1),
        .fwd_hit2 (fwd_hit2),
        .fwd_dat1 (fwd_dat1),
        .fwd_dat2 (fwd_dat2),
        .count    (count)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        RST = 1'b1; wb_valid = 1'b0; wb_sel = '0; wb_dat = '0;
        rf_grant = 1'b0; rsel1 = '0; rsel2 = '0;
        #2;
        chk("rst_count", count, 0);
        chk("rst_wen", rf_wen, 0);
        chk("rst_wsel", rf_wsel, 0);
        chk("rst_wdat", rf_wdat, 0);
        chk("rst_hit1", fwd_hit1, 0);
        chk("rst_dat2", fwd_dat2, 0);
        chk("rst_ready", wb_ready, 1);
        RST = 1'b0;
        tick();

        // Single push then immediate commit
        wb_valid = 1'b1; wb_sel = 5'd5; wb_dat = 32'hDEADBEEF; rf_grant = 1'b1; #1;
        chk("t1_ready", wb_ready, 1);
        chk("t1_wen_empty", rf_wen, 0);
        tick();
        wb_valid = 1'b0; #1;
        chk("t1_wen", rf_wen, 1);
        chk("t1_wsel", rf_wsel, 5);
        chk("t1_wdat", rf_wdat, 32'hDEADBEEF);
        chk("t1_count", count, 1);
        tick();
        chk("t1_count_after", count, 0);
        chk("t1_wen_after", rf_wen, 0);

        // Push to register 0 is accepted and dropped
        wb_valid = 1'b1; wb_sel = 5'd0; wb_dat = 32'h1234; rsel1 = 5'd0; #1;
        chk("t2_ready", wb_ready, 1);
        tick();
        wb_valid = 1'b0; #1;
        chk("t2_count", count, 0);
        chk("t2_wen", rf_wen, 0);
        chk("t2_hit1", fwd_hit1, 0);

        // Fill with grant low, then drain in order
        rf_grant = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            wb_valid = 1'b1; wb_sel = 5'(i); wb_dat = 32'h100 + 32'(i); #1;
            chk("t3_fill_ready", wb_ready, 1);
            tick();
        end
        wb_valid = 1'b0; rsel1 = 5'd3; #1;
        chk("t3_count_full", count, 4);
        chk("t3_ready_full", wb_ready, 0);
        chk("t3_hit1", fwd_hit1, 1);
        chk("t3_dat1", fwd_dat1, 32'h103);
        wb_valid = 1'b1; wb_sel = 5'd9; wb_dat = 32'h999;
        tick();
        wb_valid = 1'b0; #1;
        chk("t3_count_blocked", count, 4);
        chk("t3_head_kept", rf_wsel, 1);
        rf_grant = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            #1;
            chk("t3_drain_wen", rf_wen, 1);
            chk("t3_drain_wsel", rf_wsel, 32'(i));
            chk("t3_drain_wdat", rf_wdat, 32'h100 + 32'(i));
            tick();
        end
        chk("t3_empty", count, 0);
        chk("t3_wen_empty", rf_wen, 0);

        // Youngest-match forwarding
        rf_grant = 1'b0; rsel2 = 5'd7;
        wb_valid = 1'b1; wb_sel = 5'd7; wb_dat = 32'h11; #1;
        chk("t4_push_not_fwd", fwd_hit2, 0);
        tick();
        chk("t4_hit_first", fwd_hit2, 1);
        chk("t4_dat_first", fwd_dat2, 32'h11);
        wb_dat = 32'h22;
        tick();
        wb_valid = 1'b0; rf_grant = 1'b1; #1;
        chk("t4_hit2", fwd_hit2, 1);
        chk("t4_dat2", fwd_dat2, 32'h22);
        chk("t4_count", count, 2);
        tick();
        chk("t4_dat_after_pop", fwd_dat2, 32'h22);
        tick();
        chk("t4_hit_empty", fwd_hit2, 0);
        chk("t4_dat_empty", fwd_dat2, 0);
        rsel2 = 5'd0;

        // Full queue streaming across pointer wrap
        rf_grant = 1'b0;
        for (int i = 0; i < 4; i++) begin
            wb_valid = 1'b1; wb_sel = 5'(10 + i); wb_dat = 32'hA0 + 32'(i);
            exp_sel.push_back(5'(10 + i)); exp_dat.push_back(32'hA0 + 32'(i));
            tick();
        end
        rf_grant = 1'b1;
        for (int k = 0; k < 10; k++) begin
            wb_sel = 5'(14 + k); wb_dat = 32'hB00 + 32'(k); #1;
            chk("t5_ready", wb_ready, 1);
            chk("t5_wen", rf_wen, 1);
            chk("t5_count", count, 4);
            chk("t5_wsel", rf_wsel, 32'(exp_sel[0]));
            chk("t5_wdat", rf_wdat, exp_dat[0]);
            exp_sel.push_back(wb_sel); exp_dat.push_back(wb_dat);
            void'(exp_sel.pop_front()); void'(exp_dat.pop_front());
            tick();
        end
        wb_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("t5_tail_wsel", rf_wsel, 32'(exp_sel[0]));
            chk("t5_tail_wdat", rf_wdat, exp_dat[0]);
            void'(exp_sel.pop_front()); void'(exp_dat.pop_front());
            tick();
        end
        chk("t5_empty", count, 0);

        // Asynchronous reset with entries pending
        rf_grant = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            wb_valid = 1'b1; wb_sel = 5'(i); wb_dat = 32'hC0 + 32'(i);
            tick();
        end
        wb_valid = 1'b0; rf_grant = 1'b1; rsel1 = 5'd1; #1;
        chk("t6_pre_wen", rf_wen, 1);
        chk("t6_pre_count", count, 3);
        #2 RST = 1'b1;
        #1;
        chk("t6_rst_wen", rf_wen, 0);
        chk("t6_rst_count", count, 0);
        chk("t6_rst_hit1", fwd_hit1, 0);
        tick();
        RST = 1'b0;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("t6_no_stale_wen", rf_wen, 0);
            chk("t6_no_stale_count", count, 0);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
